// File: rtl/run_monitor_if.sv
// run_monitor_if: run-control and statistics bundle between a harness and run_monitor.
//   start        : begin a run (honoured only when no run is in progress)
//   cpu_done     : CPU halt level
//   commit_valid : one bit per instruction retiring this cycle
//   flush        : pipeline flush / redirect this cycle
//   busy, finished, timed_out, end_pulse : run status
//   cycle_count, retire_count, flush_count, max_idle : run statistics
// master = harness side, slave = monitor side.
interface run_monitor_if #(
  parameter int unsigned CYCLE_WIDTH  = 32,
  parameter int unsigned COMMIT_WIDTH = 2
);
  logic                    start;
  logic                    cpu_done;
  logic [COMMIT_WIDTH-1:0] commit_valid;
  logic                    flush;
  logic                    busy;
  logic                    finished;
  logic                    timed_out;
  logic                    end_pulse;
  logic [CYCLE_WIDTH-1:0]  cycle_count;
  logic [CYCLE_WIDTH-1:0]  retire_count;
  logic [CYCLE_WIDTH-1:0]  flush_count;
  logic [CYCLE_WIDTH-1:0]  max_idle;

  modport master (
    output start, cpu_done, commit_valid, flush,
    input  busy, finished, timed_out, end_pulse,
    input  cycle_count, retire_count, flush_count, max_idle
  );

  modport slave (
    input  start, cpu_done, commit_valid, flush,
    output busy, finished, timed_out, end_pulse,
    output cycle_count, retire_count, flush_count, max_idle
  );
endinterface

// File: rtl/run_monitor.sv
// run_monitor: run controller and statistics for the core bring-up harness.
// Tracks a run from start through cpu_done, an optional drain window and a
// watchdog timeout, and keeps saturating cycle/retire/flush counters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   mon        : run_monitor_if.slave (controls in, status/statistics out)
// Optional feature macro: RUN_MONITOR_IDLE_TRACK_EN builds the idle-streak
// tracker behind max_idle; without it max_idle reads 0.
// All outputs are registered.
module run_monitor #(
  parameter int unsigned CYCLE_WIDTH    = 32,
  parameter int unsigned COMMIT_WIDTH   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned DRAIN_CYCLES   = 4
) (
  input logic          clk,
  input logic          rst_n,
  run_monitor_if.slave mon
);

  localparam int unsigned POP_W   = $clog2(COMMIT_WIDTH + 1);
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned TIMEOUT_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned DRAIN_LOAD_I   = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;
  localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_LAST = CYCLE_WIDTH'(TIMEOUT_LAST_I);
  localparam logic [DRAIN_W-1:0]     DRAIN_LOAD   = DRAIN_W'(DRAIN_LOAD_I);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
  logic [CYCLE_WIDTH-1:0] retire_q, retire_d;
  logic [CYCLE_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                   busy_q, busy_d;
  logic                   finished_q, finished_d;
  logic                   timed_out_q, timed_out_d;
  logic                   end_pulse_q, end_pulse_d;

  logic [POP_W-1:0]       commits_c;
  logic                   counting_c;
  logic                   start_ok_c;

  // Saturating add; the carry-out bit marks overflow past all-ones.
  function automatic logic [CYCLE_WIDTH-1:0] sat_add(
    input logic [CYCLE_WIDTH-1:0] a,
    input logic [POP_W-1:0]       b
  );
    logic [CYCLE_WIDTH:0] s;
    s = {1'b0, a} + (CYCLE_WIDTH+1)'(b);
    return s[CYCLE_WIDTH] ? {CYCLE_WIDTH{1'b1}} : s[CYCLE_WIDTH-1:0];
  endfunction

  // Number of instructions retiring this cycle.
  always_comb begin
    commits_c = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commits_c = commits_c + POP_W'(mon.commit_valid[i]);
    end
  end

  assign counting_c = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign start_ok_c = mon.start &&
                      ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_TIMEOUT));

  // Next-state, counters and registered status.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cycle_d     = cycle_q;
    retire_d    = retire_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (mon.start) state_d = S_RUN;
      end
      S_RUN: begin
        // cpu_done takes priority over a watchdog expiry in the same cycle.
        if (mon.cpu_done) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cycle_q == TIMEOUT_LAST)) begin
          state_d = S_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (start_ok_c) begin
      drain_d     = '0;
      cycle_d     = '0;
      retire_d    = '0;
      flush_cnt_d = '0;
    end else if (counting_c) begin
      cycle_d     = sat_add(cycle_q, POP_W'(1));
      retire_d    = sat_add(retire_q, commits_c);
      flush_cnt_d = sat_add(flush_cnt_q, POP_W'(mon.flush));
    end

    busy_d      = (state_d == S_RUN) || (state_d == S_DRAIN);
    finished_d  = (state_d == S_DONE);
    timed_out_d = (state_d == S_TIMEOUT);
    end_pulse_d = counting_c && ((state_d == S_DONE) || (state_d == S_TIMEOUT));
  end

  // State and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      cycle_q     <= '0;
      retire_q    <= '0;
      flush_cnt_q <= '0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timed_out_q <= 1'b0;
      end_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cycle_q     <= cycle_d;
      retire_q    <= retire_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      timed_out_q <= timed_out_d;
      end_pulse_q <= end_pulse_d;
    end
  end

`ifdef RUN_MONITOR_IDLE_TRACK_EN
  logic [CYCLE_WIDTH-1:0] streak_q, streak_d;
  logic [CYCLE_WIDTH-1:0] max_idle_q, max_idle_d;

  // Current zero-commit streak and its high-water mark.
  always_comb begin
    streak_d   = streak_q;
    max_idle_d = max_idle_q;
    if (start_ok_c) begin
      streak_d   = '0;
      max_idle_d = '0;
    end else if (counting_c) begin
      streak_d   = (commits_c == '0) ? sat_add(streak_q, POP_W'(1)) : '0;
      max_idle_d = (streak_d > max_idle_q) ? streak_d : max_idle_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q   <= '0;
      max_idle_q <= '0;
    end else begin
      streak_q   <= streak_d;
      max_idle_q <= max_idle_d;
    end
  end

  assign mon.max_idle = max_idle_q;
`else
  assign mon.max_idle = '0;
`endif

  assign mon.busy         = busy_q;
  assign mon.finished     = finished_q;
  assign mon.timed_out    = timed_out_q;
  assign mon.end_pulse    = end_pulse_q;
  assign mon.cycle_count  = cycle_q;
  assign mon.retire_count = retire_q;
  assign mon.flush_count  = flush_cnt_q;

endmodule
